// File: rtl/demux8_tdm_if.sv
// Bus bundle for the 1:8 TDM demultiplexer: input stream, eight output slots, status.
// The in_parity/parity_err pair exists only when DEMUX8_PARITY_EN is defined.
interface demux8_tdm_if #(
    parameter int WIDTH = 8
);
    logic               mode;
    logic [WIDTH-1:0]   in_data;
    logic [2:0]         in_sel;
    logic               in_sof;
    logic               in_valid;
    logic               in_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [2:0]         cur_ch;
    logic               frame_err;
`ifdef DEMUX8_PARITY_EN
    logic               in_parity;
    logic               parity_err;

    modport master (
        output mode, in_data, in_sel, in_sof, in_valid, out_ready, in_parity,
        input  in_ready, out_data, out_valid, cur_ch, frame_err, parity_err
    );
    modport slave (
        input  mode, in_data, in_sel, in_sof, in_valid, out_ready, in_parity,
        output in_ready, out_data, out_valid, cur_ch, frame_err, parity_err
    );
`else
    modport master (
        output mode, in_data, in_sel, in_sof, in_valid, out_ready,
        input  in_ready, out_data, out_valid, cur_ch, frame_err
    );
    modport slave (
        input  mode, in_data, in_sel, in_sof, in_valid, out_ready,
        output in_ready, out_data, out_valid, cur_ch, frame_err
    );
`endif
endinterface

// File: rtl/demux8_tdm.sv
// 1-to-8 time-division demultiplexer with one-deep registered slot per channel.
// Optional even-parity drop of bad beats is enabled with DEMUX8_PARITY_EN.
module demux8_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             rdy_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] data_o
);
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A write wins over a drain so a full slot refills with no bubble.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (wr_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end else if (vld_q && rdy_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
endmodule

module demux8_tdm #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    demux8_tdm_if.slave  bus
);
    typedef struct packed {
        logic             wr;
        logic [2:0]       ch;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    logic [7:0][WIDTH-1:0] slot_data;
    logic [7:0]            slot_vld;
    logic [2:0]            tgt;
    logic                  rdy;
    logic                  acc;
    logic                  par_ok;
    wr_req_t               req;

    logic [2:0] cur_ch_q, cur_ch_d;
    logic       frame_err_q, frame_err_d;

    // A start-of-frame beat always lands on ch0, whatever the counter says.
    always_comb begin
        tgt = bus.in_sel;
        if (bus.mode) tgt = bus.in_sof ? 3'd0 : cur_ch_q;
    end

    assign rdy          = ~slot_vld[tgt] | bus.out_ready[tgt];
    assign acc          = bus.in_valid & rdy;
    assign bus.in_ready = rdy;

`ifdef DEMUX8_PARITY_EN
    logic parity_err_q;
    assign par_ok = ~^{bus.in_parity, bus.in_data};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) parity_err_q <= 1'b0;
        else        parity_err_q <= acc & ~par_ok;
    end
    assign bus.parity_err = parity_err_q;
`else
    assign par_ok = 1'b1;
`endif

    assign req.wr   = acc & par_ok;
    assign req.ch   = tgt;
    assign req.data = bus.in_data;

    for (genvar k = 0; k < 8; k++) begin : g_slot
        demux8_slot #(.WIDTH(WIDTH)) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_i   (req.wr && (req.ch == 3'(k))),
            .data_i (req.data),
            .rdy_i  (bus.out_ready[k]),
            .vld_o  (slot_vld[k]),
            .data_o (slot_data[k])
        );
    end

    // Counter advances on every accepted mode-1 beat, even a dropped one.
    always_comb begin
        cur_ch_d    = cur_ch_q;
        frame_err_d = 1'b0;
        if (bus.mode && acc) begin
            cur_ch_d    = tgt + 3'd1;
            frame_err_d = bus.in_sof && (cur_ch_q != 3'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch_q    <= 3'd0;
            frame_err_q <= 1'b0;
        end else begin
            cur_ch_q    <= cur_ch_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.out_data  = slot_data;
    assign bus.out_valid = slot_vld;
    assign bus.cur_ch    = cur_ch_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: doc/demux8_tdm.md
Name: demux8_tdm

Overview:
- 1-to-8 time-division demultiplexer for WIDTH-bit words; the receive-side counterpart of the team's 8:1 bus multiplexer.
- A single valid/ready input stream is routed to one of eight output channels.
- The channel comes from an explicit select (mode 0) or a round-robin frame counter (mode 1).
- Each channel has a one-deep registered holding slot with its own valid/ready handshake, so one stalled channel only blocks beats addressed to it.

Parameters:
- WIDTH, 8, data word width in bits (1..32)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mode  input  1  0 = explicit select via in_sel; 1 = round-robin frame mode
- in_data  input  WIDTH  input word
- in_sel  input  3  target channel in mode 0; ignored in mode 1
- in_sof  input  1  start-of-frame marker, qualified by in_valid; used only in mode 1
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- out_data  output  8*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  8  per-channel slot full
- out_ready  input  8  per-channel consumer ready
- cur_ch  output  3  round-robin counter value (next target in mode 1)
- frame_err  output  1  one-cycle pulse on frame misalignment

Behaviour:
- Reset is asynchronous on rst_n low. While in reset:
  - out_data = 0, out_valid = 0, cur_ch = 0, frame_err = 0.
- Target channel tgt:
  - Mode 0: tgt = in_sel.
  - Mode 1: tgt = 0 if in_sof = 1, otherwise tgt = cur_ch.
- in_ready is combinational: in_ready = ~out_valid[tgt] | out_ready[tgt]. A full slot being drained in the same cycle can accept a new beat.
- Accept = in_valid & in_ready.
- On Accept, at the next edge: out_data slot tgt <= in_data and out_valid[tgt] <= 1. Latency is one cycle from accept to out_valid.
- Drain: out_valid[k] & out_ready[k] with no write to k that cycle sets out_valid[k] <= 0. out_data[k] holds its last value.
- Simultaneous drain and write on the same channel: the slot stays valid and takes the new data; no bubble.
- Writes to different channels in consecutive cycles are independent. Only one channel is written per cycle.
- Round-robin counter, mode 1 only:
  - On Accept: cur_ch <= tgt + 1 (mod 8). 7 wraps to 0.
  - An accept with in_sof forces the beat to ch0 and sets cur_ch <= 1.
  - in_sof accepted while cur_ch != 0 sets frame_err = 1 for exactly one cycle, registered. The beat is still delivered to ch0.
  - in_sof accepted with cur_ch = 0 is not an error.
- In mode 0, cur_ch holds its value.
- Switching mode does not clear cur_ch or any slot. A mode change takes effect in the same cycle for tgt and in_ready.
- X or invalid in_sel is not possible: all 3-bit values are legal.
- Asserting rst_n low mid-transfer discards all held words immediately.
- in_valid must not depend on in_ready. in_data, in_sel and in_sof must be stable while in_valid = 1 and in_ready = 0.

Optional Feature:
- Macro: DEMUX8_PARITY_EN.
- Enabled:
  - Extra input in_parity (1 bit) and extra output parity_err (1 bit, reset 0).
  - The even-parity check is over {in_parity, in_data}.
  - A beat with bad parity is still handshaken: in_ready follows the same rule.
  - The bad beat is dropped: no slot write, out_valid unchanged.
  - In mode 1 cur_ch still advances, so frame slots are preserved.
  - parity_err pulses 1 for one cycle.
  - frame_err evaluation is unchanged.
- Disabled: neither port exists; all beats are delivered.

Test Plan:
- Mode 0: in_sel = 5, in_data = 8'hA5, out_ready = 0 -> next cycle out_valid = 8'b0010_0000 and slot 5 = A5. A second beat to ch5 sees in_ready = 0. A beat to ch2 is accepted.
- Mode 0 simultaneous event: ch3 full with 8'h11; drive out_ready[3] = 1 and a new beat 8'h22 to ch3 in the same cycle -> in_ready = 1, out_valid[3] stays 1, slot 3 = 22.
- Mode 1: in_sof on the first of 8 beats 0x10..0x17, all out_ready = 1 -> slots 0..7 receive 10..17, cur_ch sequence 1,2,...,7,0, frame_err = 0 throughout.
- Mode 1 misalignment: after 3 beats (cur_ch = 3), a beat with in_sof and data 8'h99 -> slot 0 = 99, cur_ch = 1, frame_err high for exactly 1 cycle.
- Reset: rst_n low asynchronously between edges while slots 1 and 6 are full -> out_valid = 0, cur_ch = 0, out_data = 0 before the next clock edge.
- DEMUX8_PARITY_EN: mode 1, beat 8'h03 with in_parity = 1 (odd total) -> parity_err pulses, no slot written, cur_ch still increments.
